fpaddsub_issue: RTL and testbench



---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpaddsub.sv | 100 ++++++++++
 rtl/fpaddsub_issue.sv | 106 ++++++++++
 tb/tb_fpaddsub_issue.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP types and constants for the add/sub issue stage and its neighbours.
package fpu_pkg;

   localparam int unsigned FP_N_BIT   = 32;
   localparam int unsigned FP_TAG_BIT = 4;

   localparam logic [FP_N_BIT-1:0] FP_QNAN    = 32'h7FC0_0000;
   localparam logic [FP_N_BIT-1:0] FP_POS_INF = 32'h7F80_0000;
   localparam logic [FP_N_BIT-1:0] FP_NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic [FP_N_BIT-1:0]   a;
      logic [FP_N_BIT-1:0]   b;
      logic                  sub;
      logic [FP_TAG_BIT-1:0] tag;
   } fp_req_t;

   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
   } fp_flags_t;

endpackage

// File: rtl/fpaddsub.sv
// Combinational IEEE-754 add/subtract, round-to-nearest-even, subnormals supported.
// Every NaN outcome is the sign-set default quiet NaN.
module fpaddsub #(
   parameter  int unsigned LOG_BIT = 5,
   parameter  int unsigned EXP_BIT = 8,
   localparam int unsigned N_BIT   = 1 << LOG_BIT
) (
   input  logic [N_BIT-1:0] a,
   input  logic [N_BIT-1:0] b,
   input  logic             addnot_sub,
   output logic [N_BIT-1:0] result_c
);

   localparam int unsigned MW  = N_BIT - EXP_BIT - 1;
   localparam int unsigned SW  = MW + 1;
   localparam int unsigned XW  = SW + 3;
   localparam int unsigned EW  = EXP_BIT + 2;
   localparam int unsigned LZW = $clog2(XW + 1);

   localparam logic [EXP_BIT-1:0] EXP_ONES = '1;
   localparam logic [N_BIT-1:0]   QNAN     = {1'b1, EXP_ONES, 1'b1, (MW-1)'(0)};

   logic               sa, sb, sx, sy, swap;
   logic [EXP_BIT-1:0] ea, eb, ex, ey, diff;
   logic               a_nan, b_nan, a_inf, b_inf;
   logic [N_BIT-2:0]   ax, ay;
   logic [SW-1:0]      mx, my;
   logic [XW-1:0]      y_ext, y_al, norm;
   logic [XW:0]        x_ext, sum;
   logic [LZW-1:0]     lz;
   logic [EW-1:0]      lim, sh, e_n;
   logic [EXP_BIT-1:0] e_fld;
   logic               rnd;
   logic [N_BIT-2:0]   mag;

   function automatic logic [LZW-1:0] lzc(input logic [XW-1:0] v);
      logic [LZW-1:0] n;
      n = LZW'(XW);
      for (int i = 0; i < XW; i++) begin
         if (v[i]) n = LZW'(XW - 1 - i);
      end
      return n;
   endfunction

   always_comb begin
      sh    = '0;
      sa    = a[N_BIT-1];
      sb    = b[N_BIT-1] ^ addnot_sub;
      ea    = a[N_BIT-2 -: EXP_BIT];
      eb    = b[N_BIT-2 -: EXP_BIT];
      a_nan = (ea == EXP_ONES) && (a[MW-1:0] != '0);
      b_nan = (eb == EXP_ONES) && (b[MW-1:0] != '0);
      a_inf = (ea == EXP_ONES) && (a[MW-1:0] == '0);
      b_inf = (eb == EXP_ONES) && (b[MW-1:0] == '0);

      // Larger magnitude goes to x so the aligned difference is never negative
      swap = b[N_BIT-2:0] > a[N_BIT-2:0];
      sx   = swap ? sb : sa;
      sy   = swap ? sa : sb;
      ax   = swap ? b[N_BIT-2:0] : a[N_BIT-2:0];
      ay   = swap ? a[N_BIT-2:0] : b[N_BIT-2:0];
      ex   = (ax[N_BIT-2 -: EXP_BIT] == '0) ? EXP_BIT'(1) : ax[N_BIT-2 -: EXP_BIT];
      ey   = (ay[N_BIT-2 -: EXP_BIT] == '0) ? EXP_BIT'(1) : ay[N_BIT-2 -: EXP_BIT];
      mx   = {ax[N_BIT-2 -: EXP_BIT] != '0, ax[MW-1:0]};
      my   = {ay[N_BIT-2 -: EXP_BIT] != '0, ay[MW-1:0]};
      diff = ex - ey;

      // Guard, round and sticky bits below the significand
      y_ext = {my, 3'b000};
      if (32'(diff) >= XW) y_al = XW'(|y_ext);
      else y_al = (y_ext >> diff) | XW'(|(y_ext & ~({XW{1'b1}} << diff)));

      x_ext = {1'b0, mx, 3'b000};
      sum   = (sx == sy) ? x_ext + {1'b0, y_al} : x_ext - {1'b0, y_al};

      // Left shift is capped so the exponent never drops below the subnormal floor
      lz  = lzc(sum[XW-1:0]);
      lim = EW'(ex) - EW'(1);
      if (sum[XW]) begin
         norm = {sum[XW:2], sum[1] | sum[0]};
         e_n  = EW'(ex) + EW'(1);
      end else begin
         sh   = (EW'(lz) > lim) ? lim : EW'(lz);
         norm = sum[XW-1:0] << sh;
         e_n  = EW'(ex) - sh;
      end

      e_fld = norm[XW-1] ? e_n[EXP_BIT-1:0] : '0;
      rnd   = norm[2] & (norm[3] | norm[1] | norm[0]);
      mag   = {e_fld, norm[XW-2 -: MW]} + (N_BIT-1)'(rnd);

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) result_c = QNAN;
      else if (a_inf)                                        result_c = {sa, EXP_ONES, MW'(0)};
      else if (b_inf)                                        result_c = {sb, EXP_ONES, MW'(0)};
      else if (sum == '0)                                    result_c = {sa & sb, (N_BIT-1)'(0)};
      else if (e_n >= EW'(EXP_ONES))                         result_c = {sx, EXP_ONES, MW'(0)};
      else                                                   result_c = {sx, mag};
   end

endmodule

// File: rtl/fpaddsub_issue.sv
// Issue/retire wrapper around fpaddsub: in-order request queue feeding a
// registered output stage, both with valid/ready handshakes.
module fpaddsub_issue
   import fpu_pkg::*;
#(
   parameter  int unsigned LOG_BIT = 5,
   parameter  int unsigned EXP_BIT = 8,
   parameter  int unsigned TAG_BIT = 4,
   parameter  int unsigned DEPTH   = 4,
   localparam int unsigned N_BIT   = 1 << LOG_BIT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N_BIT-1:0]   in_a,
   input  logic [N_BIT-1:0]   in_b,
   input  logic               in_sub,
   input  logic [TAG_BIT-1:0] in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N_BIT-1:0]   out_result,
   output logic [TAG_BIT-1:0] out_tag,
   output logic               out_nan,
   output logic               out_inf,
   output logic               out_zero
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned MW = N_BIT - EXP_BIT - 1;

   fp_req_t          mem [DEPTH];
   fp_req_t          req, head;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      count, count_nxt;
   logic             push, load;
   logic [N_BIT-1:0] res_c;
   fp_flags_t        flags_c;

   assign req.a   = in_a;
   assign req.b   = in_b;
   assign req.sub = in_sub;
   assign req.tag = in_tag;
   assign head    = mem[rd_ptr];

   assign push      = in_valid && in_ready;
   assign load      = (count != '0) && (!out_valid || out_ready);
   assign count_nxt = count + (PW+1)'(push) - (PW+1)'(load);

   fpaddsub #(
      .LOG_BIT (LOG_BIT),
      .EXP_BIT (EXP_BIT)
   ) u_fpaddsub (
      .a          (head.a),
      .b          (head.b),
      .addnot_sub (head.sub),
      .result_c   (res_c)
   );

   // Classification ignores sign for inf and zero
   always_comb begin
      flags_c.nan  = (res_c[N_BIT-2 -: EXP_BIT] == '1) && (res_c[MW-1:0] != '0);
      flags_c.inf  = (res_c[N_BIT-2 -: EXP_BIT] == '1) && (res_c[MW-1:0] == '0);
      flags_c.zero = (res_c[N_BIT-2:0] == '0);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= req;
   end

   // Queue control and output valid; flush shares the reset path
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (load) rd_ptr <= rd_ptr + PW'(1);
         count    <= count_nxt;
         in_ready <= (count_nxt != (PW+1)'(DEPTH));
         if (load)           out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_result <= '0;
         out_tag    <= '0;
         out_nan    <= 1'b0;
         out_inf    <= 1'b0;
         out_zero   <= 1'b0;
      end else if (load && !flush) begin
         out_result <= res_c;
         out_tag    <= head.tag;
         out_nan    <= flags_c.nan;
         out_inf    <= flags_c.inf;
         out_zero   <= flags_c.zero;
      end
   end

endmodule

// File: tb/tb_fpaddsub_issue.sv
// Self-checking bench for fpaddsub_issue: directed cases plus randomized traffic
// scored against a real-arithmetic IEEE single-precision reference.
module tb_fpaddsub_issue;
   import fpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_sub = 1'b0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic [3:0]  out_tag;
   logic        out_nan, out_inf, out_zero;

   always #5 clk = ~clk;

   fpaddsub_issue #(
      .LOG_BIT (5),
      .EXP_BIT (8),
      .TAG_BIT (4),
      .DEPTH   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sub     (in_sub),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .out_nan    (out_nan),
      .out_inf    (out_inf),
      .out_zero   (out_zero)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   logic last_acc = 1'b0;

   localparam logic [31:0] NEG_QNAN = FP_QNAN | 32'h8000_0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] flags_of(input logic [31:0] x);
      logic nan, inf, zero;
      nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      inf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      zero = (x[30:0] == 0);
      return {nan, inf, zero};
   endfunction

   function automatic real fp_val(input logic [31:0] x);
      real v;
      int  e;
      e = int'(x[30:23]);
      if (e == 0) v = real'(x[22:0]) * (2.0 ** (-149));
      else        v = (real'(x[22:0]) + 8388608.0) * (2.0 ** (e - 150));
      return x[31] ? -v : v;
   endfunction

   // Round a double to single, nearest-even; double-width intermediate keeps add exact enough
   function automatic logic [31:0] to_single(input real r);
      logic [63:0] d, m, kept, rem, half;
      logic        s;
      int          e, sh;
      d  = $realtobits(r);
      s  = d[63];
      e  = int'(d[62:52]) - 1023;
      m  = {11'b0, 1'b1, d[51:0]};
      sh = (e >= -126) ? 29 : 29 + (-126 - e);
      if (sh > 60) return {s, 31'b0};
      kept = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
      if (e >= -126) begin
         if (kept[24]) begin
            kept = kept >> 1;
            e    = e + 1;
         end
         if (e > 127) return {s, 8'hFF, 23'b0};
         return {s, 8'(e + 127), kept[22:0]};
      end
      return {s, kept[30:0]};
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
      logic [31:0] bb;
      logic [2:0]  fa, fb;
      real         r;
      bb = {b[31] ^ sub, b[30:0]};
      fa = flags_of(a);
      fb = flags_of(bb);
      if (fa[2] || fb[2]) return NEG_QNAN;
      if (fa[1] && fb[1]) return (a[31] == bb[31]) ? a : NEG_QNAN;
      if (fa[1]) return a;
      if (fb[1]) return bb;
      r = fp_val(a) + fp_val(bb);
      if (r == 0.0) return {a[31] & bb[31], 31'b0};
      return to_single(r);
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 11))
         0: x = 32'h0000_0000;
         1: x = 32'h8000_0000;
         2: x = FP_POS_INF;
         3: x = FP_NEG_INF;
         4: x = {x[31], 8'h7F, x[22:0]};
         5: x = {x[31], 8'(0), x[22:0]};
         6: x = {x[31], 8'($urandom_range(1, 3)), x[22:0]};
         7: x = {x[31], 8'hFE, x[22:0]};
         8: x = FP_QNAN;
         default: ;
      endcase
      return x;
   endfunction

   task automatic drive_rnd(input int tag);
      in_a   = rnd_fp();
      in_b   = ($urandom_range(0, 2) == 0) ? {in_a[31] ^ 1'($urandom_range(0, 1)), in_a[30:0] ^ 31'($urandom_range(0, 15))}
                                           : rnd_fp();
      in_sub = 1'($urandom_range(0, 1));
      in_tag = 4'(tag);
   endtask

   // One clock: score handshakes at the falling edge, return #1 after the rising edge
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      last_acc = in_valid && in_ready && !flush && !rst;
      if (out_valid) chk("stray_output", 32'(exp_q.size() != 0), 32'd1);
      if (out_valid && out_ready && !flush && !rst && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("sb_result", out_result, e.res);
         chk("sb_tag", 32'(out_tag), 32'(e.tag));
         chk("sb_flags", 32'({out_nan, out_inf, out_zero}), 32'(flags_of(e.res)));
      end
      if (last_acc) begin
         e.res = ref_add(in_a, in_b, in_sub);
         e.tag = in_tag;
         exp_q.push_back(e);
      end
      if (flush || rst) exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         cyc();
         k++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic op_check(input string name, input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [3:0] tag, input logic [31:0] exp_res, input logic [2:0] exp_flags);
      in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_result"}, out_result, exp_res);
      chk({name, "_tag"}, 32'(out_tag), 32'(tag));
      chk({name, "_flags"}, 32'({out_nan, out_inf, out_zero}), 32'(exp_flags));
      cyc();
   endtask

   task automatic flush_test(input bit use_rst);
      drain();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_rnd(i);
         in_valid = 1'b1;
         cyc();
      end
      chk("fl_pre_valid", 32'(out_valid), 32'd1);
      drive_rnd(10);
      if (use_rst) rst = 1'b1;
      else         flush = 1'b1;
      cyc();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid_cleared", 32'(out_valid), 32'd0);
      chk("fl_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("fl_no_output", 32'(out_valid), 32'd0);
      end
      drive_rnd(6);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("fl_post_valid", 32'(out_valid), 32'd1);
      chk("fl_post_tag", 32'(out_tag), 32'd6);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int nxt;
      int k;

      // Reset state
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_flags", 32'({out_nan, out_inf, out_zero}), 32'd0);

      // Directed values
      op_check("add_1_2", 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd3, 32'h4040_0000, 3'b000);
      op_check("sub_zero", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 4'd1, 32'h0000_0000, 3'b001);
      op_check("inf_m_inf", FP_POS_INF, FP_POS_INF, 1'b1, 4'd2, NEG_QNAN, 3'b100);
      op_check("nan_a", FP_QNAN, 32'h1234_5678, 1'b0, 4'd4, NEG_QNAN, 3'b100);
      op_check("inf_p_1", FP_POS_INF, 32'h3F80_0000, 1'b0, 4'd5, FP_POS_INF, 3'b010);
      op_check("ovf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 4'd6, FP_POS_INF, 3'b010);
      op_check("subn", 32'h0080_0001, 32'h0080_0000, 1'b1, 4'd7, 32'h0000_0001, 3'b000);

      // Back-pressure: DEPTH+1 accepts, then in-order drain
      out_ready = 1'b0;
      nxt = 0;
      drive_rnd(0);
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cyc();
         if (last_acc) begin
            nxt++;
            if (nxt < 8) drive_rnd(nxt);
            else in_valid = 1'b0;
         end
      end
      chk("bp_accepts", 32'(nxt), 32'd5);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("bp_drain_valid", 32'(out_valid), 32'd1);
         chk("bp_drain_tag", 32'(out_tag), 32'(c));
         cyc();
         if (last_acc) begin
            nxt++;
            if (nxt < 8) drive_rnd(nxt);
            else in_valid = 1'b0;
         end
      end
      k = 0;
      while (nxt < 8 && k < 20) begin
         cyc();
         if (last_acc) begin
            nxt++;
            if (nxt < 8) drive_rnd(nxt);
            else in_valid = 1'b0;
         end
         k++;
      end
      chk("bp_late_accepts", 32'(nxt), 32'd8);
      drain();

      // Full throughput
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive_rnd(i);
         chk("tp_in_ready", 32'(in_ready), 32'd1);
         cyc();
         if (i > 0) chk("tp_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      cyc();
      chk("tp_out_valid_last", 32'(out_valid), 32'd1);
      drain();

      // Flush and reset mid-stream
      flush_test(1'b0);
      flush_test(1'b1);

      // Randomized traffic with random back-pressure
      for (int c = 0; c < 400; c++) begin
         drive_rnd(int'($urandom_range(0, 15)));
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         cyc();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
